// File: rtl/latency_mem_pkg.sv
// Shared types and defaults for the latency_mem memory responder.
package latency_mem_pkg;

  localparam int unsigned DEF_ADDR_WIDTH    = 64;
  localparam int unsigned DEF_WORD_WIDTH    = 64;
  localparam int unsigned DEF_DEPTH_BITS    = 10;
  localparam int unsigned DEF_READ_LATENCY  = 1;
  localparam int unsigned DEF_WRITE_LATENCY = 2;

  // Responder FSM: IDLE accepts a request, BUSY counts down the latency.
  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_e;

  // Operation captured at acceptance; re&we together is recorded as a write.
  typedef enum logic {
    OP_READ  = 1'b0,
    OP_WRITE = 1'b1
  } op_e;

  // Latency counter width: clog2 of the larger latency plus one.
  function automatic int unsigned lat_cnt_width(input int unsigned rd_lat,
                                                input int unsigned wr_lat);
    int unsigned max_lat;
    max_lat = (rd_lat > wr_lat) ? rd_lat : wr_lat;
    return $clog2(max_lat) + 1;
  endfunction

endpackage

// File: rtl/latency_mem_if.sv
// Memory port bundle between a requester (master) and latency_mem (slave).
interface latency_mem_if
  import latency_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DEF_ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH
) ();

  logic [ADDR_WIDTH-1:0] addr;
  logic [WORD_WIDTH-1:0] din;
  logic [WORD_WIDTH-1:0] dout;
  logic                  re;
  logic                  we;
  logic                  ready;
  logic                  range_err;
  logic                  proto_err;

  modport master (
    output addr, din, re, we,
    input  dout, ready, range_err, proto_err
  );

  modport slave (
    input  addr, din, re, we,
    output dout, ready, range_err, proto_err
  );

endinterface

// File: rtl/latency_mem_store.sv
// Word array with per-word valid bits; sync write, combinational read,
// valid bits cleared asynchronously so reset forgets all stored data.
module latency_mem_store
  import latency_mem_pkg::*;
#(
  parameter int unsigned DEPTH_BITS = DEF_DEPTH_BITS,
  parameter int unsigned WORD_WIDTH = DEF_WORD_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  wr_en_i,
  input  logic [DEPTH_BITS-1:0] wr_idx_i,
  input  logic [WORD_WIDTH-1:0] wr_data_i,
  input  logic [DEPTH_BITS-1:0] rd_idx_i,
  output logic [WORD_WIDTH-1:0] rd_data_o,
  output logic                  rd_valid_o
);

  localparam int unsigned DEPTH = 1 << DEPTH_BITS;

  logic [WORD_WIDTH-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]      valid_q;

  // Data array: no reset, contents are qualified by the valid bits.
  always_ff @(posedge clk) begin
    if (wr_en_i) begin
      mem_q[wr_idx_i] <= wr_data_i;
    end
  end

  // Valid bits: set on write, cleared by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_q <= '0;
    end else if (wr_en_i) begin
      valid_q[wr_idx_i] <= 1'b1;
    end
  end

  assign rd_data_o  = mem_q[rd_idx_i];
  assign rd_valid_o = valid_q[rd_idx_i];

endmodule

// File: rtl/latency_mem.sv
// Memory-side responder: one request at a time, programmable read/write
// latency, unwritten or out-of-range words read as all-ones, sticky errors.
module latency_mem
  import latency_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
  parameter int unsigned WORD_WIDTH    = DEF_WORD_WIDTH,
  parameter int unsigned DEPTH_BITS    = DEF_DEPTH_BITS,
  parameter int unsigned READ_LATENCY  = DEF_READ_LATENCY,
  parameter int unsigned WRITE_LATENCY = DEF_WRITE_LATENCY
) (
  input  logic          clk,
  input  logic          rst,
  latency_mem_if.slave  bus
);

  localparam int unsigned     CNT_W   = lat_cnt_width(READ_LATENCY, WRITE_LATENCY);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(READ_LATENCY - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WRITE_LATENCY - 1);

  state_e                state_q,     state_d;
  logic [CNT_W-1:0]      cnt_q,       cnt_d;
  op_e                   op_q,        op_d;
  logic [DEPTH_BITS-1:0] idx_q,       idx_d;
  logic [WORD_WIDTH-1:0] wdata_q,     wdata_d;
  logic                  oor_q,       oor_d;
  logic [WORD_WIDTH-1:0] dout_q,      dout_d;
  logic                  ready_q,     ready_d;
  logic                  range_err_q, range_err_d;
  logic                  proto_err_q, proto_err_d;

  logic                  req_c;
  logic                  addr_oor_c;
  logic                  st_wr_en_c;
  logic [WORD_WIDTH-1:0] st_rdata;
  logic                  st_rvalid;

  latency_mem_store #(
    .DEPTH_BITS (DEPTH_BITS),
    .WORD_WIDTH (WORD_WIDTH)
  ) u_store (
    .clk        (clk),
    .rst        (rst),
    .wr_en_i    (st_wr_en_c),
    .wr_idx_i   (idx_q),
    .wr_data_i  (wdata_q),
    .rd_idx_i   (idx_q),
    .rd_data_o  (st_rdata),
    .rd_valid_o (st_rvalid)
  );

  assign req_c      = bus.re | bus.we;
  assign addr_oor_c = (bus.addr >> DEPTH_BITS) != '0;

  // State, capture and output registers; reset abandons any in-flight op.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      op_q        <= OP_READ;
      idx_q       <= '0;
      wdata_q     <= '0;
      oor_q       <= 1'b0;
      dout_q      <= '1;
      ready_q     <= 1'b1;
      range_err_q <= 1'b0;
      proto_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      op_q        <= op_d;
      idx_q       <= idx_d;
      wdata_q     <= wdata_d;
      oor_q       <= oor_d;
      dout_q      <= dout_d;
      ready_q     <= ready_d;
      range_err_q <= range_err_d;
      proto_err_q <= proto_err_d;
    end
  end

  // Next-state: accept in IDLE, count down in BUSY, complete when counter hits 0.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    op_d        = op_q;
    idx_d       = idx_q;
    wdata_d     = wdata_q;
    oor_d       = oor_q;
    dout_d      = dout_q;
    ready_d     = ready_q;
    range_err_d = range_err_q;
    proto_err_d = proto_err_q;
    st_wr_en_c  = 1'b0;

    // Requests while busy are dropped; re&we is downgraded to a write.
    if ((req_c && !ready_q) || (bus.re && bus.we)) begin
      proto_err_d = 1'b1;
    end

    unique case (state_q)
      ST_IDLE: begin
        if (ready_q && req_c) begin
          op_d    = bus.we ? OP_WRITE : OP_READ;
          idx_d   = bus.addr[DEPTH_BITS-1:0];
          wdata_d = bus.din;
          oor_d   = addr_oor_c;
          cnt_d   = bus.we ? WR_LOAD : RD_LOAD;
          ready_d = 1'b0;
          state_d = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (cnt_q == '0) begin
          ready_d = 1'b1;
          state_d = ST_IDLE;
          if (oor_q) begin
            range_err_d = 1'b1;
          end
          if (op_q == OP_WRITE) begin
            st_wr_en_c = !oor_q;
          end else begin
            dout_d = (!oor_q && st_rvalid) ? st_rdata : '1;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: begin
        state_d = ST_IDLE;
        ready_d = 1'b1;
      end
    endcase
  end

  assign bus.dout      = dout_q;
  assign bus.ready     = ready_q;
  assign bus.range_err = range_err_q;
  assign bus.proto_err = proto_err_q;

endmodule

// File: tb/tb_latency_mem.sv
// Directed and random checks of latency_mem against a small reference model.
module tb_latency_mem;
  import latency_mem_pkg::*;

  localparam int unsigned AW = 64;
  localparam int unsigned WW = 64;
  localparam int unsigned DB = 10;
  localparam int unsigned RL = 1;
  localparam int unsigned WL = 2;
  localparam logic [63:0] ONES = '1;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  latency_mem_if #(.ADDR_WIDTH(AW), .WORD_WIDTH(WW)) bus ();

  latency_mem #(
    .ADDR_WIDTH    (AW),
    .WORD_WIDTH    (WW),
    .DEPTH_BITS    (DB),
    .READ_LATENCY  (RL),
    .WRITE_LATENCY (WL)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [63:0] ref_mem [1024];
  bit          ref_val [1024];
  logic [63:0] ref_dout;
  bit          ref_rerr;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic model_clear();
    foreach (ref_val[i]) ref_val[i] = 1'b0;
    ref_dout = ONES;
    ref_rerr = 1'b0;
  endtask

  // Issue one request from an idle cycle (#1 after an edge) and wait for ready.
  task automatic do_op(input string tag, input bit rd, input bit wr,
                       input logic [63:0] a, input logic [63:0] d);
    int n;
    int exp_lat;
    bit oor;
    logic [9:0] ix;
    bus.re = rd; bus.we = wr; bus.addr = a; bus.din = d;
    @(posedge clk); #1;
    bus.re = 1'b0; bus.we = 1'b0;
    n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    oor = (a >= 64'd1024);
    ix  = a[9:0];
    if (wr) begin
      exp_lat = WL;
      if (!oor) begin
        ref_mem[ix] = d;
        ref_val[ix] = 1'b1;
      end
    end else begin
      exp_lat  = RL;
      ref_dout = (!oor && ref_val[ix]) ? ref_mem[ix] : ONES;
    end
    if (oor) ref_rerr = 1'b1;
    chk({tag, "/lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "/dout"}, bus.dout, ref_dout);
  endtask

  // Watchdog so a stuck DUT cannot hang the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bus.re = 1'b0; bus.we = 1'b0; bus.addr = '0; bus.din = '0;
    rst = 1'b1;
    model_clear();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst_ready", 64'(bus.ready), 64'd1);
    chk("rst_dout", bus.dout, ONES);
    chk("rst_rerr", 64'(bus.range_err), 64'd0);
    chk("rst_perr", 64'(bus.proto_err), 64'd0);

    // Write then read back
    do_op("t2w", 1'b0, 1'b1, 64'd1, 64'h0123456789abcdef);
    do_op("t2r", 1'b1, 1'b0, 64'd1, 64'd0);
    chk("t2_val", bus.dout, 64'h0123456789abcdef);

    // Unwritten word, second address, earlier data intact
    do_op("t3r0", 1'b1, 1'b0, 64'd0, 64'd0);
    chk("t3_unwr", bus.dout, ONES);
    do_op("t3w", 1'b0, 1'b1, 64'd257, 64'd123);
    chk("t3_wr_keeps_dout", bus.dout, ONES);
    do_op("t3r257", 1'b1, 1'b0, 64'd257, 64'd0);
    chk("t3_257", bus.dout, 64'd123);
    do_op("t3r1", 1'b1, 1'b0, 64'd1, 64'd0);
    chk("t3_1", bus.dout, 64'h0123456789abcdef);

    // Out-of-range accesses, no aliasing onto index 0
    chk("t4_rerr_pre", 64'(bus.range_err), 64'd0);
    do_op("t4r", 1'b1, 1'b0, 64'd1024, 64'd0);
    chk("t4_oor_rd", bus.dout, ONES);
    chk("t4_rerr", 64'(bus.range_err), 64'd1);
    do_op("t4w", 1'b0, 1'b1, 64'd1024, 64'd7);
    do_op("t4r0", 1'b1, 1'b0, 64'd0, 64'd0);
    chk("t4_alias", bus.dout, ONES);

    // Write while busy is ignored; re&we at idle acts as a write
    chk("t5_perr_pre", 64'(bus.proto_err), 64'd0);
    bus.we = 1'b1; bus.addr = 64'd9; bus.din = 64'haaaa;
    @(posedge clk); #1;
    chk("t5_busy", 64'(bus.ready), 64'd0);
    bus.din = 64'hbad0;
    @(posedge clk); #1;
    bus.we = 1'b0;
    n = 0;
    while (bus.ready !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    chk("t5_lat", 64'(n), 64'd1);
    ref_mem[9] = 64'haaaa;
    ref_val[9] = 1'b1;
    chk("t5_perr", 64'(bus.proto_err), 64'd1);
    do_op("t5r9", 1'b1, 1'b0, 64'd9, 64'd0);
    chk("t5_intact", bus.dout, 64'haaaa);
    do_op("t5rw", 1'b1, 1'b1, 64'd12, 64'h55);
    chk("t5_rw_no_read", bus.dout, 64'haaaa);
    do_op("t5r12", 1'b1, 1'b0, 64'd12, 64'd0);
    chk("t5_rw_stored", bus.dout, 64'h55);

    // Reset mid-write drops the write and restores ready at once
    bus.we = 1'b1; bus.addr = 64'd5; bus.din = 64'h77;
    @(posedge clk); #1;
    bus.we = 1'b0;
    chk("t6_busy", 64'(bus.ready), 64'd0);
    #2 rst = 1'b1;
    #1;
    chk("t6_ready", 64'(bus.ready), 64'd1);
    chk("t6_dout", bus.dout, ONES);
    chk("t6_perr", 64'(bus.proto_err), 64'd0);
    chk("t6_rerr", 64'(bus.range_err), 64'd0);
    model_clear();
    @(posedge clk); #1;
    rst = 1'b0;
    do_op("t6r5", 1'b1, 1'b0, 64'd5, 64'd0);
    chk("t6_dropped", bus.dout, ONES);
    do_op("t6r9", 1'b1, 1'b0, 64'd9, 64'd0);
    chk("t6_cleared", bus.dout, ONES);

    // Random back-to-back traffic against the model
    for (int i = 0; i < 500; i++) begin
      int mode;
      logic [63:0] a;
      logic [63:0] d;
      mode = int'($urandom_range(0, 9));
      if ($urandom_range(0, 9) == 0) a = 64'(1020 + $urandom_range(0, 8));
      else                           a = 64'($urandom_range(0, 31));
      d = {$urandom, $urandom};
      if (mode < 5)      do_op("rnd_rd", 1'b1, 1'b0, a, d);
      else if (mode < 9) do_op("rnd_wr", 1'b0, 1'b1, a, d);
      else               do_op("rnd_rw", 1'b1, 1'b1, a, d);
    end
    chk("rnd_rerr", 64'(bus.range_err), 64'(ref_rerr));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
